// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares one memory port between the instruction-fetch path and the data
//   (load/store) path. One transaction on the bus at a time; the data path
//   has fixed priority over fetch. Granted request attributes are latched on
//   grant, so the bus stays stable while the requester changes its inputs.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch read request (held until if_ack)
//   if_rdata/if_ack     fetch data + one-cycle completion pulse
//   mem_req/we/sel/addr/wdata   data-access request (held until mem_ack)
//   mem_rdata/mem_ack   data read result + one-cycle completion pulse
//   bus_req/we/sel/addr/wdata   shared memory port, request side
//   bus_rdata/bus_ready shared memory port, response side (latency >= 1)
//   stallreq_if/mem     stall requests to the pipeline controller
//   bus_err             one-cycle timeout pulse
//
// Configuration
//   BUS_TIMEOUT_EN      when defined, a transfer that sees 16 cycles of
//                       bus_ready=0 is abandoned: ack pulses with rdata 0 and
//                       bus_err pulses alongside. Undefined: waits forever,
//                       bus_err tied low.
// ---------------------------------------------------------------------------
module bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_XFER  = 2'd1,
        MEM_XFER = 2'd2
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        if_ack_q;
    logic        mem_ack_q;

    // A requester whose ack is showing this cycle has just been served; its
    // req is still high until it reacts, so it must not be granted again.
    logic if_elig;
    logic mem_elig;
    assign if_elig  = if_req  & ~if_ack_q;
    assign mem_elig = mem_req & ~mem_ack_q;

`ifdef BUS_TIMEOUT_EN
    logic [3:0] tmo_cnt_q;
    logic       bus_err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= 4'h0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            // Acks and the error flag are single-cycle pulses.
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_elig) begin
                        state_q <= MEM_XFER;
                        we_q    <= mem_we;
                        sel_q   <= mem_sel;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt_q <= 4'h0;
`endif
                    end else if (if_elig) begin
                        state_q <= IF_XFER;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        addr_q  <= if_addr;
                        wdata_q <= 32'h0;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt_q <= 4'h0;
`endif
                    end
                end
                IF_XFER, MEM_XFER: begin
                    if (bus_ready) begin
                        state_q <= IDLE;
                        if (state_q == IF_XFER) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus_rdata;
                        end else begin
                            mem_ack_q <= 1'b1;
                            // Writes leave the last read result untouched.
                            if (!we_q) mem_rdata_q <= bus_rdata;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt_q == 4'hF) begin
                        // 16th stalled cycle: abandon and complete with zero data.
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                        if (state_q == IF_XFER) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= 32'h0;
                        end else begin
                            mem_ack_q   <= 1'b1;
                            mem_rdata_q <= 32'h0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 4'h1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus request follows the state directly so an async reset drops it at once.
    assign bus_req   = (state_q != IDLE);
    assign bus_we    = we_q;
    assign bus_sel   = sel_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ack   = mem_ack_q;

    assign stallreq_if  = if_req  & ~if_ack_q;
    assign stallreq_mem = mem_req & ~mem_ack_q;

`ifdef BUS_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
    );

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // XFER cycle in which bus_ready is raised (>=1)
        logic [31:0] rdata;      // data presented on the bus
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;  // requester rdata after the ack
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int idx);
        vec_t v;
        v = vecs[idx];
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk1("stall_req_cycle", v.is_mem ? stallreq_mem : stallreq_if, 1'b1);
        step();
        chk1("grant_bus_req", bus_req, 1'b1);
        chk("grant_bus_addr", bus_addr, v.addr);
        chk1("grant_bus_we", bus_we, v.exp_we);
        chk("grant_bus_sel", {28'h0, bus_sel}, {28'h0, v.exp_sel});
        chk("grant_bus_wdata", bus_wdata, v.exp_wdata);
        chk1("stall_xfer", v.is_mem ? stallreq_mem : stallreq_if, 1'b1);
        // Requester scribbles on its inputs; the latched attributes must hold.
        if (v.is_mem) begin
            mem_addr = ~v.addr; mem_wdata = ~v.wdata; mem_we = ~v.we;
        end else begin
            if_addr = ~v.addr;
        end
        for (int k = 1; k < v.lat; k++) begin
            step();
            chk1("wait_bus_req", bus_req, 1'b1);
            chk("wait_bus_addr", bus_addr, v.addr);
            chk1("wait_bus_we", bus_we, v.exp_we);
            chk("wait_bus_wdata", bus_wdata, v.exp_wdata);
            chk1("wait_no_ack", v.is_mem ? mem_ack : if_ack, 1'b0);
        end
        bus_ready = 1'b1;
        bus_rdata = v.rdata;
        step();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        chk1("ack_pulse", v.is_mem ? mem_ack : if_ack, 1'b1);
        chk1("other_ack_quiet", v.is_mem ? if_ack : mem_ack, 1'b0);
        chk("ack_rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        chk1("ack_bus_req_low", bus_req, 1'b0);
        chk1("ack_stall_low", v.is_mem ? stallreq_mem : stallreq_if, 1'b0);
        chk1("ack_bus_err", bus_err, 1'b0);
        if (v.is_mem) mem_req = 1'b0; else if_req = 1'b0;
        step();
        chk1("ack_one_cycle", v.is_mem ? mem_ack : if_ack, 1'b0);
        chk1("no_reissue", bus_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mem  we    sel    addr          wdata         lat rdata         ewe   esel   ewdata        erdata
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        1, 32'h2402_0005, 1'b0, 4'hF, 32'h0,        32'h2402_0005};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0,        1, 32'h1234_5678, 1'b0, 4'hF, 32'h0,        32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0300, 32'hDEAD_BEEF, 3, 32'hAAAA_AAAA, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,        2, 32'h8C01_0000, 1'b0, 4'hF, 32'h0,        32'h8C01_0000};
        vecs[4] = '{1'b1, 1'b0, 4'h4, 32'h0000_0400, 32'h0,        4, 32'hCAFE_F00D, 1'b0, 4'h4, 32'h0,        32'hCAFE_F00D};

        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_rdata = 32'h0; bus_ready = 1'b0;

        // Reset state
        #2;
        chk1("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_mem_ack", mem_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk1("rst_bus_err", bus_err, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) run_txn(i);

        // Simultaneous requests: mem first, fetch right after mem_ack
        if_req = 1'b1; if_addr = 32'h0000_0108;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0200;
        step();
        chk("prio_mem_first", bus_addr, 32'h0000_0200);
        chk1("prio_stall_if", stallreq_if, 1'b1);
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
        step();
        bus_ready = 1'b0;
        chk1("prio_mem_ack", mem_ack, 1'b1);
        chk1("prio_if_wait", if_ack, 1'b0);
        chk("prio_mem_rdata", mem_rdata, 32'h0BAD_F00D);
        chk1("prio_stall_if_ack", stallreq_if, 1'b1);
        mem_req = 1'b0;
        step();
        chk1("prio_if_grant", bus_req, 1'b1);
        chk("prio_if_addr", bus_addr, 32'h0000_0108);
        chk1("prio_stall_if_xfer", stallreq_if, 1'b1);
        bus_ready = 1'b1; bus_rdata = 32'h0000_1111;
        step();
        bus_ready = 1'b0;
        chk1("prio_if_ack", if_ack, 1'b1);
        chk("prio_if_rdata", if_rdata, 32'h0000_1111);
        if_req = 1'b0;
        step();

        // Fetch with the bus never ready
        if_req = 1'b1; if_addr = 32'h0000_0500;
        step();
        chk1("tmo_xfer1", bus_req, 1'b1);
        for (int k = 2; k <= 16; k++) begin
            step();
            chk1("tmo_still_busy", bus_req, 1'b1);
            chk1("tmo_no_err_yet", bus_err, 1'b0);
        end
        step();
`ifdef BUS_TIMEOUT_EN
        chk1("tmo_bus_req_drop", bus_req, 1'b0);
        chk1("tmo_if_ack", if_ack, 1'b1);
        chk("tmo_if_rdata", if_rdata, 32'h0);
        chk1("tmo_bus_err", bus_err, 1'b1);
        if_req = 1'b0;
        step();
        chk1("tmo_err_one_cycle", bus_err, 1'b0);
        chk1("tmo_ack_one_cycle", if_ack, 1'b0);
`else
        chk1("notmo_bus_req", bus_req, 1'b1);
        chk1("notmo_bus_err", bus_err, 1'b0);
        chk1("notmo_no_ack", if_ack, 1'b0);
        bus_ready = 1'b1; bus_rdata = 32'h5555_0000;
        step();
        bus_ready = 1'b0;
        chk1("notmo_late_ack", if_ack, 1'b1);
        chk("notmo_late_rdata", if_rdata, 32'h5555_0000);
        if_req = 1'b0;
        step();
`endif

        // Async reset in the middle of a mem transfer
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h0000_0600; mem_wdata = 32'h1;
        step();
        chk1("arst_pre_bus_req", bus_req, 1'b1);
        #2;
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        chk1("arst_bus_req", bus_req, 1'b0);
        chk("arst_bus_addr", bus_addr, 32'h0);
        chk1("arst_bus_we", bus_we, 1'b0);
        chk("arst_mem_rdata", mem_rdata, 32'h0);
        chk("arst_if_rdata", if_rdata, 32'h0);
        chk1("arst_stall_mem", stallreq_mem, 1'b0);
        bus_ready = 1'b1;
        step();
        chk1("arst_no_mem_ack", mem_ack, 1'b0);
        bus_ready = 1'b0;

        // First grant on the first edge after reset release
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0700;
        step();
        chk1("post_rst_grant", bus_req, 1'b1);
        chk("post_rst_addr", bus_addr, 32'h0000_0700);
        bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
        step();
        bus_ready = 1'b0;
        chk1("post_rst_ack", if_ack, 1'b1);
        chk("post_rst_rdata", if_rdata, 32'h7777_7777);
        if_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
